// File: rtl/rfsoc_config_pkg.sv
// rtl/rfsoc_config_pkg.sv - shared RFSoC config widths, GPIO bit map and sequencer types
package rfsoc_config;

  localparam int config_reg_width = 256;

  // PS GPIO bus bit map
  localparam int GPIO_SDATA_IDX           = 0;
  localparam int GPIO_CYCLE_COUNT_CLK_IDX = 1;
  localparam int GPIO_PL_RST_IDX          = 2;
  localparam int GPIO_TRIGGER_IDX         = 3;
  localparam int GPIO_PRE_DELAY_CLK_IDX   = 4;
  localparam int GPIO_POST_DELAY_CLK_IDX  = 5;
  localparam int GPIO_USED_BITS           = 6;

  typedef logic [config_reg_width-1:0] cfg_word_t;

  typedef enum logic [1:0] {
    DAC_SEQ_IDLE = 2'd0,
    DAC_SEQ_PRE  = 2'd1,
    DAC_SEQ_RUN  = 2'd2,
    DAC_SEQ_POST = 2'd3
  } dac_seq_state_t;

endpackage

// File: rtl/dac_seq_ctrl_gpio_sync_edge.sv
// rtl/dac_seq_ctrl_gpio_sync_edge.sv - GPIO bit synchroniser with registered rising-edge pulse
module gpio_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  // STAGES must be at least 2 for metastability protection
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/dac_seq_ctrl.sv
// rtl/dac_seq_ctrl.sv - per-channel DAC playback sequencer: serial count load, PRE/RUN/POST FSM
module dac_seq_ctrl
  import rfsoc_config::*;
#(
  parameter int CFG_WIDTH   = config_reg_width,
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic                  chan_sel,
  output logic                  run_en,
  output logic                  run_start,
  output logic                  done,
  output logic                  busy
);

  localparam logic [CFG_WIDTH-1:0] CNT_ONE = {{(CFG_WIDTH-1){1'b0}}, 1'b1};

  logic [GPIO_USED_BITS-1:0] gpio_level;
  logic [GPIO_USED_BITS-1:0] gpio_rise;

  // Sync chains only see rst so the pl_rst chain cannot clear itself
  for (genvar i = 0; i < GPIO_USED_BITS; i++) begin : g_sync
    gpio_sync_edge #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (gpio_in[i]),
      .level (gpio_level[i]),
      .rise  (gpio_rise[i])
    );
  end

  logic unused_gpio;
  assign unused_gpio = ^{gpio_in[GPIO_WIDTH-1:GPIO_USED_BITS],
                         gpio_level[GPIO_CYCLE_COUNT_CLK_IDX], gpio_level[GPIO_TRIGGER_IDX],
                         gpio_level[GPIO_PRE_DELAY_CLK_IDX], gpio_level[GPIO_POST_DELAY_CLK_IDX],
                         gpio_rise[GPIO_SDATA_IDX], gpio_rise[GPIO_PL_RST_IDX]};

  logic int_rst;
  logic sdata_sync;
  logic trig_fire;

  assign int_rst    = rst | gpio_level[GPIO_PL_RST_IDX];
  assign sdata_sync = gpio_level[GPIO_SDATA_IDX];
  assign trig_fire  = gpio_rise[GPIO_TRIGGER_IDX];

  logic [CFG_WIDTH-1:0] pre_reg;
  logic [CFG_WIDTH-1:0] run_reg;
  logic [CFG_WIDTH-1:0] post_reg;

  always_ff @(posedge clk) begin
    if (int_rst) begin
      pre_reg  <= '0;
      run_reg  <= '0;
      post_reg <= '0;
    end else if (chan_sel) begin
      if (gpio_rise[GPIO_PRE_DELAY_CLK_IDX])
        pre_reg <= {pre_reg[CFG_WIDTH-2:0], sdata_sync};
      if (gpio_rise[GPIO_CYCLE_COUNT_CLK_IDX])
        run_reg <= {run_reg[CFG_WIDTH-2:0], sdata_sync};
      if (gpio_rise[GPIO_POST_DELAY_CLK_IDX])
        post_reg <= {post_reg[CFG_WIDTH-2:0], sdata_sync};
    end
  end

  dac_seq_state_t       state, next_state;
  logic [CFG_WIDTH-1:0] cnt, next_cnt;
  logic [CFG_WIDTH-1:0] run_snap;
  logic [CFG_WIDTH-1:0] post_snap;

  // The pre count is consumed straight into cnt, so only later phases need snapshots
  always_ff @(posedge clk) begin
    if (int_rst) begin
      run_snap  <= '0;
      post_snap <= '0;
    end else if (state == DAC_SEQ_IDLE && trig_fire) begin
      run_snap  <= run_reg;
      post_snap <= post_reg;
    end
  end

  logic run_en_d, run_start_d, done_d, busy_d;

  always_ff @(posedge clk) begin
    if (int_rst) begin
      state     <= DAC_SEQ_IDLE;
      cnt       <= '0;
      run_en    <= 1'b0;
      run_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      run_en    <= run_en_d;
      run_start <= run_start_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      DAC_SEQ_IDLE: begin
        if (trig_fire) begin
          if (pre_reg != '0) begin
            next_state = DAC_SEQ_PRE;
            next_cnt   = pre_reg - CNT_ONE;
          end else if (run_reg != '0) begin
            next_state = DAC_SEQ_RUN;
            next_cnt   = run_reg - CNT_ONE;
          end else if (post_reg != '0) begin
            next_state = DAC_SEQ_POST;
            next_cnt   = post_reg - CNT_ONE;
          end
        end
      end
      DAC_SEQ_PRE: begin
        if (cnt != '0) begin
          next_cnt = cnt - CNT_ONE;
        end else if (run_snap != '0) begin
          next_state = DAC_SEQ_RUN;
          next_cnt   = run_snap - CNT_ONE;
        end else if (post_snap != '0) begin
          next_state = DAC_SEQ_POST;
          next_cnt   = post_snap - CNT_ONE;
        end else begin
          next_state = DAC_SEQ_IDLE;
        end
      end
      DAC_SEQ_RUN: begin
        if (cnt != '0) begin
          next_cnt = cnt - CNT_ONE;
        end else if (post_snap != '0) begin
          next_state = DAC_SEQ_POST;
          next_cnt   = post_snap - CNT_ONE;
        end else begin
          next_state = DAC_SEQ_IDLE;
        end
      end
      DAC_SEQ_POST: begin
        if (cnt != '0)
          next_cnt = cnt - CNT_ONE;
        else
          next_state = DAC_SEQ_IDLE;
      end
      default: next_state = DAC_SEQ_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register
  always_comb begin
    run_en_d    = (next_state == DAC_SEQ_RUN);
    run_start_d = (next_state == DAC_SEQ_RUN) && (state != DAC_SEQ_RUN);
    busy_d      = (next_state != DAC_SEQ_IDLE);
    done_d      = (next_state == DAC_SEQ_IDLE) && ((state != DAC_SEQ_IDLE) || trig_fire);
  end

endmodule
